prog_device: RTL and testbench
==============================

// Module: prog_device
// PURPOSE
//   Top-level compute block: finds the index of the least-significant '0' bit
//   of the 32-bit switch word SW.
//   Operation is multi-cycle: it samples SW on the first clock after reset
//   release, scans it one bit per clock from bit 0 upward, then holds the
//   result on HEX.
//   HEX drives the board display/readout as a plain binary number.
//   A new search starts only after another reset pulse.
// PARAMETERS
//   WIDTH    32   data width of SW, HEX and the scan register
//   IDX_W    6    width of the bit-index counter; must hold the value WIDTH
// PORTS
//   clk   in   1      system clock, all state updates on rising edge
//   rst   in   1      synchronous, active-high reset
//   SW    in   WIDTH  operand word; must be stable from reset release until DONE
//   HEX   out  WIDTH  result: index of lowest zero bit, zero-extended
// BEHAVIOUR
//   Clocking and reset:
//   - Single clock domain.
//   - Reset is synchronous and active-high: sampled only on the rising edge of clk.
//   - While rst=1 at an edge: state<=LOAD, HEX<=0, shift reg<=0, idx<=0.
//   - rst wins over every other event, including mid-scan and after DONE.
//   FSM states: LOAD, SCAN, DONE.
//   - LOAD (first edge with rst=0): shreg<=SW, idx<=0, ->SCAN. HEX stays 0.
//   - SCAN, each edge:
//       if shreg[0]==0      : HEX<=idx, ->DONE
//       else if idx==WIDTH-1: HEX<=WIDTH (32), ->DONE  (all ones, no zero)
//       else                : shreg<=shreg>>1, idx<=idx+1, stay in SCAN
//   - DONE: HEX holds; SW ignored; remain until rst.
//   Latency:
//   - Result valid k+2 rising edges after the first edge with rst=0, where k is
//     the answer index; worst case WIDTH+1 edges (33).
//   - HEX reads 0 until the result is written.
//   - Bench must not sample before 34 edges after reset release.
//   Width rules:
//   - idx is IDX_W bits and never wraps; the maximum value written is WIDTH.
//   - HEX upper bits [WIDTH-1:IDX_W] are always 0.
//   Boundaries:
//   - SW=0 -> 0.
//   - SW all ones -> 32.
//   - SW bit0=0 -> result 0, 2 edges after reset release.
//   - SW change during SCAN is not tracked: the value sampled in LOAD is used.
//   - SW change during DONE has no effect.
//   - Reset mid-scan aborts the scan, clears HEX to 0, and restarts from LOAD
//     on release.
//   - Repeated runs with no rst between them are impossible: DONE is terminal.
// TESTING
//   Each case: rst=1 for 3 cycles, release, run 1000 cycles, then check HEX.
//   - SW=32'b1011_1011 -> HEX=2
//   - SW=32'b11_1000 -> HEX=0 (bit0 zero; valid 2 edges after release)
//   - SW=32'b1011_1111_1111 -> HEX=10
//   - SW=32'h0000_FFFF -> HEX=16; SW=32'hEF -> HEX=4
//   - SW=32'hFFFF_FFFF -> HEX=32; SW=32'h7FFF_FFFF -> HEX=31
//   - Assert rst for 1 cycle mid-scan (SW=32'h0000_FFFF, 5 cycles after release)
//       -> HEX=0 immediately, then 16 after the rerun completes.
//   - Change SW after DONE -> HEX unchanged.

Source files
------------

// File: rtl/prog_device.sv
`default_nettype none
// ============================================================================
//  prog_device : index of the least-significant zero bit of SW, found by a
//                one-bit-per-clock scan and held on HEX until the next reset.
//  Revision    : 1.0
// ============================================================================
module prog_device #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] HEX
);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
   localparam logic [WIDTH-1:0] C_NO_ZERO  = WIDTH'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [WIDTH-1:0] hex_q,   hex_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         shreg_q <= '0;
         idx_q   <= '0;
         hex_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         hex_q   <= hex_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      hex_d   = hex_q;
      unique case (state_q)
         LOAD: begin
            shreg_d = SW;
            idx_d   = '0;
            state_d = SCAN;
         end
         SCAN: begin
            if (!shreg_q[0]) begin
               hex_d   = WIDTH'(idx_q);
               state_d = DONE;
            end else if (idx_q == C_LAST_IDX) begin
               // every bit was one: report WIDTH as "no zero found"
               hex_d   = C_NO_ZERO;
               state_d = DONE;
            end else begin
               shreg_d = shreg_q >> 1;
               idx_d   = idx_q + C_IDX_ONE;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   assign HEX = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_device.sv
`default_nettype none
// ============================================================================
//  tb_prog_device : directed vector table plus multi-cycle corner sequences.
//  Revision       : 1.0
// ============================================================================
module tb_prog_device;

   logic        clk;
   logic        rst;
   logic [31:0] SW;
   logic [31:0] HEX;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] sw;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   prog_device #(.WIDTH(32), .IDX_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .SW  (SW),
      .HEX (HEX)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: HEX=%0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
      end
   endtask

   // Holds rst for 3 edges; returns at the negedge where rst is released.
   task automatic do_reset(input logic [31:0] sw);
      @(negedge clk);
      SW  = sw;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      SW  = '0;

      vecs[0] = '{32'b1011_1011,      32'd2};
      vecs[1] = '{32'b11_1000,        32'd0};
      vecs[2] = '{32'b1011_1111_1111, 32'd10};
      vecs[3] = '{32'h0000_FFFF,      32'd16};
      vecs[4] = '{32'h0000_00EF,      32'd4};
      vecs[5] = '{32'hFFFF_FFFF,      32'd32};
      vecs[6] = '{32'h7FFF_FFFF,      32'd31};
      vecs[7] = '{32'h0000_0000,      32'd0};
      vecs[8] = '{32'h8000_FFFF,      32'd16};

      for (int i = 0; i < 9; i++) begin
         do_reset(vecs[i].sw);
         check($sformatf("reset_clear_%0d", i), HEX, 32'd0);
         edges(1000);
         check($sformatf("vec_%0d", i), HEX, vecs[i].exp);
      end

      // Latency: answer k appears exactly k+2 edges after release.
      do_reset(32'b1011_1011);
      edges(3);
      check("lat_k2_early", HEX, 32'd0);
      edges(1);
      check("lat_k2_ontime", HEX, 32'd2);

      do_reset(32'b11_1000);
      edges(1);
      check("lat_k0_early", HEX, 32'd0);
      do_reset(32'b11_1001);
      edges(2);
      check("lat_k1_early", HEX, 32'd0);
      edges(1);
      check("lat_k1_ontime", HEX, 32'd1);

      do_reset(32'hFFFF_FFFF);
      edges(32);
      check("lat_ones_early", HEX, 32'd0);
      edges(1);
      check("lat_ones_ontime", HEX, 32'd32);

      // Reset mid-scan aborts, then a rerun completes normally.
      do_reset(32'h0000_FFFF);
      edges(5);
      rst = 1'b1;
      edges(1);
      check("midscan_rst_clear", HEX, 32'd0);
      rst = 1'b0;
      edges(40);
      check("midscan_rerun", HEX, 32'd16);

      // Reset after DONE clears the held result.
      rst = 1'b1;
      edges(1);
      check("done_rst_clear", HEX, 32'd0);
      rst = 1'b0;
      edges(40);
      check("done_rst_rerun", HEX, 32'd16);

      // SW changes during SCAN are not tracked.
      do_reset(32'h0000_FFFF);
      edges(3);
      SW = 32'h0000_0000;
      edges(40);
      check("sw_change_scan", HEX, 32'd16);

      // SW changes after DONE have no effect.
      SW = 32'h0000_0007;
      edges(40);
      check("sw_change_done", HEX, 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
